// File: rtl/axi_slave_mux_w_if.sv
// axi_slave_mux_w_if
//   AXI4 write-path bundle (AW, W and B channels) shared by the internal
//   s2m port and the two downstream slave ports of axi_slave_mux_w.
//
//   master modport : drives AW/W payload and valid, drives b_ready;
//                    receives aw_ready, w_ready and the B channel.
//   slave modport  : the mirror image of master.
//
//   Parameters:
//     DATA_WIDTH  W data width
//     ADDR_WIDTH  AW address width
//     ID_WIDTH    aw_id / b_id width
//     USER_WIDTH  aw_user / w_user / b_user width
//     STRB_WIDTH  w_strb width
interface axi_slave_mux_w_if #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  // AW channel
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  aw_lock;
  logic [3:0]            aw_cache;
  logic [2:0]            aw_prot;
  logic [3:0]            aw_qos;
  logic [3:0]            aw_region;
  logic [USER_WIDTH-1:0] aw_user;

  // W channel
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_last;
  logic [USER_WIDTH-1:0] w_user;
  logic                  w_valid;
  logic                  w_ready;

  // B channel
  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;
  logic [USER_WIDTH-1:0] b_user;
  logic                  b_valid;
  logic                  b_ready;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_qos, aw_region, aw_user,
           w_data, w_strb, w_last, w_user, w_valid,
           b_ready,
    input  aw_ready, w_ready,
           b_id, b_resp, b_user, b_valid
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_qos, aw_region, aw_user,
           w_data, w_strb, w_last, w_user, w_valid,
           b_ready,
    output aw_ready, w_ready,
           b_id, b_resp, b_user, b_valid
  );
endinterface

// File: rtl/axi_slave_mux_w.sv
// axi_slave_mux_w
//   Write-path slave mux. Routes one AXI4 write transaction at a time from
//   the internal s2m port to slave m0 or m1, chosen by aw_addr[SEL_BIT]
//   (0 -> m0, 1 -> m1). The choice is latched at the AW handshake so the
//   W beats and the B response stay with that slave even if aw_addr moves.
//   W beats are counted against aw_len; the downstream w_last is generated
//   from that count, and any disagreement with the incoming w_last sets the
//   sticky wlast_err flag.
//
//   Ports:
//     ACLK       clock
//     ARESETn    synchronous active-low reset
//     s2m        internal write port (slave side of the bundle)
//     m0, m1     downstream slave ports (master side of the bundle)
//     wlast_err  sticky: incoming w_last disagreed with the beat count
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for AW; aw_valid/aw_ready routed by live aw_addr bit
//   DATA  | passing W beats to slave sel_q, counting against len_q
//   RESP  | passing the B response from slave sel_q back to s2m
module axi_slave_mux_w #(
  parameter int SEL_BIT = 31
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  axi_slave_mux_w_if.slave  s2m,
  axi_slave_mux_w_if.master m0,
  axi_slave_mux_w_if.master m1,
  output logic             wlast_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       sel_q;
  logic [7:0] len_q;
  logic [7:0] beat_q;

  logic aw_sel;
  logic last_beat;
  logic aw_ready_sel;
  logic w_ready_sel;
  logic b_valid_sel;

  logic m0_aw_valid;
  logic m1_aw_valid;
  logic aw_ready;
  logic m0_w_valid;
  logic m1_w_valid;
  logic w_ready;
  logic b_valid;
  logic m0_b_ready;
  logic m1_b_ready;
  logic aw_fire;
  logic w_fire;
  logic b_fire;

  assign aw_sel       = s2m.aw_addr[SEL_BIT];
  assign last_beat    = (beat_q == len_q);
  assign aw_ready_sel = aw_sel ? m1.aw_ready : m0.aw_ready;
  assign w_ready_sel  = sel_q  ? m1.w_ready  : m0.w_ready;
  assign b_valid_sel  = sel_q  ? m1.b_valid  : m0.b_valid;

  // AW and W payloads fan out to both slaves; only valid/ready are steered.
  assign m0.aw_id     = s2m.aw_id;
  assign m0.aw_addr   = s2m.aw_addr;
  assign m0.aw_len    = s2m.aw_len;
  assign m0.aw_size   = s2m.aw_size;
  assign m0.aw_burst  = s2m.aw_burst;
  assign m0.aw_lock   = s2m.aw_lock;
  assign m0.aw_cache  = s2m.aw_cache;
  assign m0.aw_prot   = s2m.aw_prot;
  assign m0.aw_qos    = s2m.aw_qos;
  assign m0.aw_region = s2m.aw_region;
  assign m0.aw_user   = s2m.aw_user;
  assign m0.w_data    = s2m.w_data;
  assign m0.w_strb    = s2m.w_strb;
  assign m0.w_user    = s2m.w_user;

  assign m1.aw_id     = s2m.aw_id;
  assign m1.aw_addr   = s2m.aw_addr;
  assign m1.aw_len    = s2m.aw_len;
  assign m1.aw_size   = s2m.aw_size;
  assign m1.aw_burst  = s2m.aw_burst;
  assign m1.aw_lock   = s2m.aw_lock;
  assign m1.aw_cache  = s2m.aw_cache;
  assign m1.aw_prot   = s2m.aw_prot;
  assign m1.aw_qos    = s2m.aw_qos;
  assign m1.aw_region = s2m.aw_region;
  assign m1.aw_user   = s2m.aw_user;
  assign m1.w_data    = s2m.w_data;
  assign m1.w_strb    = s2m.w_strb;
  assign m1.w_user    = s2m.w_user;

  // Downstream w_last comes from the beat count, never from s2m.w_last, so
  // a misbehaving upstream cannot truncate or overrun the slave's burst.
  assign m0.w_last = last_beat;
  assign m1.w_last = last_beat;

  // B payload always reflects the latched slave; only b_valid is gated.
  assign s2m.b_id   = sel_q ? m1.b_id   : m0.b_id;
  assign s2m.b_resp = sel_q ? m1.b_resp : m0.b_resp;
  assign s2m.b_user = sel_q ? m1.b_user : m0.b_user;

  assign m0.aw_valid  = m0_aw_valid;
  assign m1.aw_valid  = m1_aw_valid;
  assign s2m.aw_ready = aw_ready;
  assign m0.w_valid   = m0_w_valid;
  assign m1.w_valid   = m1_w_valid;
  assign s2m.w_ready  = w_ready;
  assign s2m.b_valid  = b_valid;
  assign m0.b_ready   = m0_b_ready;
  assign m1.b_ready   = m1_b_ready;

  // Handshake signals are held low while ARESETn is asserted so nothing
  // handshakes on the reset edge, whatever state the FSM was left in.
  always_comb begin
    state_d     = state_q;
    m0_aw_valid = 1'b0;
    m1_aw_valid = 1'b0;
    aw_ready    = 1'b0;
    m0_w_valid  = 1'b0;
    m1_w_valid  = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    m0_b_ready  = 1'b0;
    m1_b_ready  = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    b_fire      = 1'b0;
    if (ARESETn) begin
      case (state_q)
        IDLE: begin
          m0_aw_valid = s2m.aw_valid & ~aw_sel;
          m1_aw_valid = s2m.aw_valid &  aw_sel;
          aw_ready    = aw_ready_sel;
          aw_fire     = s2m.aw_valid & aw_ready_sel;
          if (aw_fire) state_d = DATA;
        end
        DATA: begin
          m0_w_valid = s2m.w_valid & ~sel_q;
          m1_w_valid = s2m.w_valid &  sel_q;
          w_ready    = w_ready_sel;
          w_fire     = s2m.w_valid & w_ready_sel;
          if (w_fire && last_beat) state_d = RESP;
        end
        RESP: begin
          b_valid    = b_valid_sel;
          m0_b_ready = s2m.b_ready & ~sel_q;
          m1_b_ready = s2m.b_ready &  sel_q;
          b_fire     = b_valid_sel & s2m.b_ready;
          if (b_fire) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      wlast_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_fire) begin
        sel_q  <= aw_sel;
        len_q  <= s2m.aw_len;
        beat_q <= 8'd0;
      end
      // beat_q only wraps on the final beat of a 256-beat burst, at which
      // point the FSM has already left DATA and the count is dead.
      if (w_fire) begin
        beat_q <= beat_q + 8'd1;
        if (s2m.w_last != last_beat) wlast_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mux_w.sv
module tb_axi_slave_mux_w;
  localparam int DW  = 64;
  localparam int AW  = 64;
  localparam int IW  = 8;
  localparam int UW  = 8;
  localparam int SW  = DW / 8;
  localparam int SEL = 31;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic wlast_err;

  axi_slave_mux_w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                       .USER_WIDTH(UW), .STRB_WIDTH(SW)) s2m ();
  axi_slave_mux_w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                       .USER_WIDTH(UW), .STRB_WIDTH(SW)) m0 ();
  axi_slave_mux_w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                       .USER_WIDTH(UW), .STRB_WIDTH(SW)) m1 ();

  axi_slave_mux_w #(.SEL_BIT(SEL)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .s2m       (s2m.slave),
    .m0        (m0.master),
    .m1        (m1.master),
    .wlast_err (wlast_err)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_err = 1'b0;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    int          wl_at;
    logic [1:0]  bresp;
    bit          chg;
    bit          exp_sel;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no handshake within cycle budget at %0t", name, $time);
  endtask

  function automatic logic aw_v(input bit s);
    return s ? m1.aw_valid : m0.aw_valid;
  endfunction
  function automatic logic w_v(input bit s);
    return s ? m1.w_valid : m0.w_valid;
  endfunction
  function automatic logic w_l(input bit s);
    return s ? m1.w_last : m0.w_last;
  endfunction
  function automatic logic b_r(input bit s);
    return s ? m1.b_ready : m0.b_ready;
  endfunction
  function automatic logic [DW-1:0] w_d(input bit s);
    return s ? m1.w_data : m0.w_data;
  endfunction
  function automatic logic [AW-1:0] aw_a(input bit s);
    return s ? m1.aw_addr : m0.aw_addr;
  endfunction

  task automatic idle_all();
    s2m.aw_valid = 0; s2m.aw_id = 0; s2m.aw_addr = 0; s2m.aw_len = 0;
    s2m.aw_size = 0; s2m.aw_burst = 0; s2m.aw_lock = 0; s2m.aw_cache = 0;
    s2m.aw_prot = 0; s2m.aw_qos = 0; s2m.aw_region = 0; s2m.aw_user = 0;
    s2m.w_data = 0; s2m.w_strb = 0; s2m.w_last = 0; s2m.w_user = 0;
    s2m.w_valid = 0; s2m.b_ready = 0;
    m0.aw_ready = 0; m0.w_ready = 0; m0.b_id = 0; m0.b_resp = 0; m0.b_user = 0; m0.b_valid = 0;
    m1.aw_ready = 0; m1.w_ready = 0; m1.b_id = 0; m1.b_resp = 0; m1.b_user = 0; m1.b_valid = 0;
  endtask

  task automatic random_inputs();
    s2m.aw_valid = 1'($urandom); s2m.aw_id = IW'($urandom);
    s2m.aw_addr = {$urandom, $urandom}; s2m.aw_len = 8'($urandom);
    s2m.aw_user = UW'($urandom);
    s2m.w_data = {$urandom, $urandom}; s2m.w_last = 1'($urandom);
    s2m.w_valid = 1'($urandom); s2m.b_ready = 1'($urandom);
    m0.aw_ready = 1'($urandom); m0.w_ready = 1'($urandom); m0.b_valid = 1'($urandom);
    m1.aw_ready = 1'($urandom); m1.w_ready = 1'($urandom); m1.b_valid = 1'($urandom);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_m0_aw_valid"}, m0.aw_valid, 0);
    chk({tag, "_m1_aw_valid"}, m1.aw_valid, 0);
    chk({tag, "_aw_ready"},    s2m.aw_ready, 0);
    chk({tag, "_m0_w_valid"},  m0.w_valid, 0);
    chk({tag, "_m1_w_valid"},  m1.w_valid, 0);
    chk({tag, "_w_ready"},     s2m.w_ready, 0);
    chk({tag, "_b_valid"},     s2m.b_valid, 0);
    chk({tag, "_m0_b_ready"},  m0.b_ready, 0);
    chk({tag, "_m1_b_ready"},  m1.b_ready, 0);
  endtask

  // One full write transaction. The reference behaviour: the slave is
  // addr[SEL]; W beat k carries last iff k == len; err is sticky whenever
  // the upstream last flag disagrees with that.
  task automatic do_txn(input logic [63:0] addr, input logic [7:0] len, input int wl_at,
                        input logic [1:0] bresp, input bit chg_addr, input bit early_w,
                        input bit b2b, input logic [63:0] next_addr, input int pct,
                        output bit got_sel);
    bit s;
    bit done;
    bit rdy;
    bit wv;
    bit wl;
    bit bv;
    bit br;
    int cyc;
    int beat;
    logic [IW-1:0] id;
    logic [IW-1:0] bid;
    logic [UW-1:0] bu;
    logic [DW-1:0] wd;
    s = addr[SEL];
    got_sel = ~s;
    id = IW'($urandom);
    s2m.aw_valid = 1; s2m.aw_addr = addr; s2m.aw_len = len; s2m.aw_id = id;
    s2m.aw_size = 3'($urandom); s2m.aw_burst = 2'($urandom); s2m.aw_user = UW'($urandom);
    if (early_w) begin
      s2m.w_valid = 1; s2m.w_data = {$urandom, $urandom}; s2m.w_last = (wl_at == 0);
    end
    done = 0; cyc = 0;
    while (!done) begin
      rdy = ($urandom_range(99) < pct);
      if (s) begin m1.aw_ready = rdy; m0.aw_ready = 1'($urandom); end
      else   begin m0.aw_ready = rdy; m1.aw_ready = 1'($urandom); end
      @(negedge ACLK);
      chk("aw_valid_sel", aw_v(s), 1);
      chk("aw_valid_other", aw_v(~s), 0);
      chk("aw_ready", s2m.aw_ready, rdy);
      chk("aw_addr_sel", aw_a(s), addr);
      chk("aw_id_sel", s ? m1.aw_id : m0.aw_id, id);
      chk("aw_len_sel", s ? m1.aw_len : m0.aw_len, len);
      chk("w_ready_idle", s2m.w_ready, 0);
      chk("w_valid_idle", m0.w_valid | m1.w_valid, 0);
      chk("b_valid_idle", s2m.b_valid, 0);
      chk("wlast_err", wlast_err, model_err);
      if (rdy) begin
        done = 1;
        got_sel = m1.aw_valid;
      end
      @(posedge ACLK); #1;
      cyc++;
      if (!done && cyc > 300) begin timeout_fail("aw_handshake"); return; end
    end
    s2m.aw_valid = 0; m0.aw_ready = 0; m1.aw_ready = 0;
    if (chg_addr) s2m.aw_addr = 0;

    beat = 0; cyc = 0;
    while (beat <= int'(len)) begin
      wv  = ($urandom_range(99) < pct) || (early_w && cyc == 0);
      rdy = ($urandom_range(99) < pct) || (early_w && cyc == 0);
      wd  = {$urandom, $urandom};
      wl  = (beat == wl_at);
      s2m.w_valid = wv; s2m.w_data = wd; s2m.w_last = wl;
      s2m.w_strb = SW'($urandom); s2m.w_user = UW'($urandom);
      if (s) begin m1.w_ready = rdy; m0.w_ready = 1'($urandom); end
      else   begin m0.w_ready = rdy; m1.w_ready = 1'($urandom); end
      @(negedge ACLK);
      chk("w_valid_sel", w_v(s), wv);
      chk("w_valid_other", w_v(~s), 0);
      chk("w_ready", s2m.w_ready, rdy);
      chk("w_last_sel", w_l(s), (beat == int'(len)));
      chk("w_data_sel", w_d(s), wd);
      chk("aw_valid_data", m0.aw_valid | m1.aw_valid, 0);
      chk("aw_ready_data", s2m.aw_ready, 0);
      chk("b_valid_data", s2m.b_valid, 0);
      chk("wlast_err", wlast_err, model_err);
      if (wv && rdy) begin
        if (wl != (beat == int'(len))) model_err = 1;
        beat++;
      end
      @(posedge ACLK); #1;
      cyc++;
      if (beat <= int'(len) && cyc > 6000) begin timeout_fail("w_beats"); return; end
    end
    s2m.w_valid = 0; s2m.w_last = 0; m0.w_ready = 0; m1.w_ready = 0;

    bid = IW'($urandom); bu = UW'($urandom);
    if (b2b) begin
      s2m.aw_valid = 1; s2m.aw_addr = next_addr; m0.aw_ready = 1; m1.aw_ready = 1;
    end
    done = 0; cyc = 0;
    while (!done) begin
      bv = ($urandom_range(99) < pct);
      br = ($urandom_range(99) < pct);
      if (s) begin
        m1.b_valid = bv; m1.b_id = bid; m1.b_resp = bresp; m1.b_user = bu;
        m0.b_valid = 1'($urandom); m0.b_id = ~bid; m0.b_resp = ~bresp; m0.b_user = ~bu;
      end else begin
        m0.b_valid = bv; m0.b_id = bid; m0.b_resp = bresp; m0.b_user = bu;
        m1.b_valid = 1'($urandom); m1.b_id = ~bid; m1.b_resp = ~bresp; m1.b_user = ~bu;
      end
      s2m.b_ready = br;
      @(negedge ACLK);
      chk("b_valid", s2m.b_valid, bv);
      chk("b_ready_sel", b_r(s), br);
      chk("b_ready_other", b_r(~s), 0);
      chk("b_id", s2m.b_id, bid);
      chk("b_resp", s2m.b_resp, bresp);
      chk("b_user", s2m.b_user, bu);
      chk("w_valid_resp", m0.w_valid | m1.w_valid, 0);
      chk("w_ready_resp", s2m.w_ready, 0);
      chk("aw_valid_resp", m0.aw_valid | m1.aw_valid, 0);
      chk("aw_ready_resp", s2m.aw_ready, 0);
      chk("wlast_err", wlast_err, model_err);
      if (bv && br) done = 1;
      @(posedge ACLK); #1;
      cyc++;
      if (!done && cyc > 300) begin timeout_fail("b_handshake"); return; end
    end
    m0.b_valid = 0; m1.b_valid = 0; s2m.b_ready = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    bit got;
    int len_r;
    int wl_r;
    logic [63:0] a_r;

    vecs[0] = '{64'h0000_1000,             8'd3,   3,   2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'h8000_0040,             8'd0,   0,   2'b10, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{64'h0000_0FF0,             8'd255, 255, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0100,             8'd1,   0,   2'b00, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{64'h0000_2000,             8'd2,   2,   2'b01, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{64'hFFFF_FFFF_7FFF_FFFF,   8'd0,   -1,  2'b11, 1'b0, 1'b0, 1'b1};

    // Reset with random inputs: nothing handshakes, flag clear.
    idle_all();
    ARESETn = 0;
    random_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      chk_quiet("reset");
      chk("reset_wlast_err", wlast_err, 0);
      @(posedge ACLK); #1;
      random_inputs();
    end
    idle_all();
    ARESETn = 1;
    model_err = 0;
    m0.aw_ready = 1;
    @(negedge ACLK);
    chk("idle_after_reset_aw_ready", s2m.aw_ready, 1);
    chk("idle_after_reset_w_ready", s2m.w_ready, 0);
    @(posedge ACLK); #1;
    m0.aw_ready = 0;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].addr, vecs[i].len, vecs[i].wl_at, vecs[i].bresp, vecs[i].chg,
             1'b0, 1'b0, 64'h0, 70, got);
      @(negedge ACLK);
      chk($sformatf("vec%0d_sel", i), got, vecs[i].exp_sel);
      chk($sformatf("vec%0d_err", i), wlast_err, vecs[i].exp_err);
      @(posedge ACLK); #1;
    end

    // W presented in IDLE before any AW: must not be accepted.
    s2m.w_valid = 1; m0.w_ready = 1; m1.w_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("early_w_ready", s2m.w_ready, 0);
      chk("early_w_m_valid", m0.w_valid | m1.w_valid, 0);
      @(posedge ACLK); #1;
    end
    do_txn(64'h8000_0800, 8'd1, 1, 2'b00, 1'b0, 1'b1, 1'b0, 64'h0, 60, got);

    // Back-to-back: second AW held through RESP, taken the cycle after B.
    do_txn(64'h8000_0200, 8'd2, 2, 2'b00, 1'b0, 1'b0, 1'b1, 64'h0000_3000, 70, got);
    do_txn(64'h0000_3000, 8'd1, 1, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 100, got);

    // Reset in the middle of DATA abandons the transaction.
    s2m.aw_valid = 1; s2m.aw_addr = 64'h0; s2m.aw_len = 8'd3; m0.aw_ready = 1;
    @(negedge ACLK);
    chk("abort_aw_ready", s2m.aw_ready, 1);
    @(posedge ACLK); #1;
    s2m.aw_valid = 0; m0.aw_ready = 0;
    s2m.w_valid = 1; s2m.w_last = 0; m0.w_ready = 1;
    @(negedge ACLK);
    chk("abort_w_ready_data", s2m.w_ready, 1);
    @(posedge ACLK); #1;
    ARESETn = 0;
    @(negedge ACLK);
    chk_quiet("abort_reset");
    @(posedge ACLK); #1;
    ARESETn = 1;
    model_err = 0;
    @(negedge ACLK);
    chk("abort_idle_w_ready", s2m.w_ready, 0);
    chk("abort_idle_m0_w_valid", m0.w_valid, 0);
    chk("abort_wlast_err", wlast_err, 0);
    @(posedge ACLK); #1;
    idle_all();
    do_txn(64'h0000_4000, 8'd2, 2, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 80, got);
    @(negedge ACLK);
    chk("after_abort_sel", got, 0);
    @(posedge ACLK); #1;

    // Randomized transactions against the reference rules.
    for (int i = 0; i < 40; i++) begin
      a_r = {$urandom, $urandom};
      len_r = ($urandom_range(9) == 0) ? 255 : int'($urandom_range(7));
      wl_r = ($urandom_range(4) == 0) ? int'($urandom_range(len_r + 1)) : len_r;
      do_txn(a_r, 8'(len_r), wl_r, 2'($urandom), 1'($urandom), 1'b0, 1'b0, 64'h0,
             int'($urandom_range(100, 50)), got);
      @(negedge ACLK);
      chk("rand_sel", got, a_r[SEL]);
      @(posedge ACLK); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
